// File: rtl/bin2bcd_seq4_if.sv
// Handshake bundle for bin2bcd_seq4: one binary sample in, packed 4-digit BCD out.
interface bin2bcd_seq4_if #(
    parameter int BIN_W = 14
);
    logic [BIN_W-1:0] iBIN;
    logic             iSTART;
    logic [15:0]      oBCD;
    logic             oVALID;
    logic             oBUSY;
    logic             oOVF;

    modport master (
        output iBIN, iSTART,
        input  oBCD, oVALID, oBUSY, oOVF
    );

    modport slave (
        input  iBIN, iSTART,
        output oBCD, oVALID, oBUSY, oOVF
    );
endinterface

// File: rtl/bin2bcd_seq4.sv
// Sequential double-dabble binary to 4-digit packed BCD; result held between conversions.
// Define BIN2BCD_SAT_EN to saturate the displayed value to 9999 on overflow.
//
// state | meaning
// IDLE  | waiting for iSTART, last result held on oBCD/oOVF
// SHIFT | one add-3/shift step per cycle, BIN_W cycles
// DONE  | publish result, pulse oVALID
module bin2bcd_seq4 #(
    parameter int BIN_W = 14
) (
    input logic          iCLK,
    input logic          iRST,
    bin2bcd_seq4_if.slave bus
);
    generate
        if (BIN_W < 4 || BIN_W > 16) begin : gBadWidth
            $error("bin2bcd_seq4: BIN_W must be within 4..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [BIN_W-1:0] shiftReg;
    logic [19:0]      scratch;
    logic [19:0]      adjusted;
    logic [4:0]       bitCnt;
    logic [15:0]      bcdReg;
    logic             ovfReg;
    logic             validReg;
    logic             overflow;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.iSTART) stateNext = SHIFT;
            SHIFT:   if (bitCnt == 5'd1) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // All five digits are corrected in parallel before the shift.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    assign overflow = (scratch[19:16] != 4'd0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            shiftReg <= '0;
            scratch  <= '0;
            bitCnt   <= '0;
            bcdReg   <= '0;
            ovfReg   <= 1'b0;
            validReg <= 1'b0;
        end else begin
            validReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iSTART) begin
                        shiftReg <= bus.iBIN;
                        scratch  <= '0;
                        bitCnt   <= 5'(BIN_W);
                    end
                end
                SHIFT: begin
                    scratch  <= {adjusted[18:0], shiftReg[BIN_W-1]};
                    shiftReg <= {shiftReg[BIN_W-2:0], 1'b0};
                    bitCnt   <= bitCnt - 5'd1;
                end
                DONE: begin
`ifdef BIN2BCD_SAT_EN
                    bcdReg <= overflow ? 16'h9999 : scratch[15:0];
`else
                    bcdReg <= scratch[15:0];
`endif
                    ovfReg   <= overflow;
                    validReg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oBCD   = bcdReg;
    assign bus.oOVF   = ovfReg;
    assign bus.oVALID = validReg;
    assign bus.oBUSY  = (state != IDLE);
endmodule

// File: tb/tb_bin2bcd_seq4.sv
// Directed self-checking bench for bin2bcd_seq4 at BIN_W = 14, 4 and 16.
module tb_bin2bcd_seq4;
    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 iCLK = ~iCLK;

    bin2bcd_seq4_if #(.BIN_W(14)) bus14 ();
    bin2bcd_seq4_if #(.BIN_W(4))  bus4  ();
    bin2bcd_seq4_if #(.BIN_W(16)) bus16 ();

    bin2bcd_seq4 #(.BIN_W(14)) dut14 (.iCLK(iCLK), .iRST(iRST), .bus(bus14));
    bin2bcd_seq4 #(.BIN_W(4))  dut4  (.iCLK(iCLK), .iRST(iRST), .bus(bus4));
    bin2bcd_seq4 #(.BIN_W(16)) dut16 (.iCLK(iCLK), .iRST(iRST), .bus(bus16));

`ifdef BIN2BCD_SAT_EN
    localparam logic [15:0] EXP_10000 = 16'h9999;
    localparam logic [15:0] EXP_16383 = 16'h9999;
    localparam logic [15:0] EXP_65535 = 16'h9999;
`else
    localparam logic [15:0] EXP_10000 = 16'h0000;
    localparam logic [15:0] EXP_16383 = 16'h6383;
    localparam logic [15:0] EXP_65535 = 16'h5535;
`endif

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] refBcd(input int v);
        int m;
        m = v % 10000;
`ifdef BIN2BCD_SAT_EN
        if (v > 9999) return 16'h9999;
`endif
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic getValid(input int sel);
        case (sel)
            4:       return bus4.oVALID;
            16:      return bus16.oVALID;
            default: return bus14.oVALID;
        endcase
    endfunction

    function automatic logic getBusy(input int sel);
        case (sel)
            4:       return bus4.oBUSY;
            16:      return bus16.oBUSY;
            default: return bus14.oBUSY;
        endcase
    endfunction

    function automatic logic [15:0] getBcd(input int sel);
        case (sel)
            4:       return bus4.oBCD;
            16:      return bus16.oBCD;
            default: return bus14.oBCD;
        endcase
    endfunction

    function automatic logic getOvf(input int sel);
        case (sel)
            4:       return bus4.oOVF;
            16:      return bus16.oOVF;
            default: return bus14.oOVF;
        endcase
    endfunction

    // Counts edges from now until oVALID is seen, bounded at 40.
    task automatic waitValid(input int sel, output int cnt, output int busyCnt);
        cnt = 0;
        busyCnt = 0;
        forever begin
            busyCnt += int'(getBusy(sel));
            if (getValid(sel) || cnt >= 40) break;
            tick();
            cnt++;
        end
    endtask

    task automatic startConv(input int sel, input int v);
        case (sel)
            4:       begin bus4.iBIN  = 4'(v);  bus4.iSTART  = 1'b1; end
            16:      begin bus16.iBIN = 16'(v); bus16.iSTART = 1'b1; end
            default: begin bus14.iBIN = 14'(v); bus14.iSTART = 1'b1; end
        endcase
        tick();
        bus4.iSTART  = 1'b0;
        bus14.iSTART = 1'b0;
        bus16.iSTART = 1'b0;
    endtask

    task automatic run(input int sel, input int v, input logic [15:0] expBcd,
                       input logic expOvf, input string tag);
        int cnt, busyCnt;
        startConv(sel, v);
        waitValid(sel, cnt, busyCnt);
        check({tag, "_lat"}, cnt, sel + 1);
        check({tag, "_busy"}, busyCnt, sel + 1);
        check({tag, "_bcd"}, getBcd(sel), expBcd);
        check({tag, "_ovf"}, getOvf(sel), expOvf);
    endtask

    initial begin
        int cnt, busyCnt, seen, busySeen, v;
        int bVals[6];
        logic [15:0] bExp[6];
        logic bOvf[6];

        bVals = '{0, 9, 10, 9999, 10000, 16383};
        bExp  = '{16'h0000, 16'h0009, 16'h0010, 16'h9999, EXP_10000, EXP_16383};
        bOvf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        bus14.iBIN = '0; bus14.iSTART = 1'b0;
        bus4.iBIN  = '0; bus4.iSTART  = 1'b0;
        bus16.iBIN = '0; bus16.iSTART = 1'b0;

        // Reset then idle
        iRST = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
        seen = 0;
        busySeen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen += int'(bus14.oVALID);
            busySeen += int'(bus14.oBUSY);
        end
        check("rst_bcd", bus14.oBCD, 16'h0000);
        check("rst_ovf", bus14.oOVF, 1'b0);
        check("rst_valid", seen, 0);
        check("rst_busy", busySeen, 0);

        // Basic conversion and hold
        run(14, 1234, 16'h1234, 1'b0, "basic");
        tick();
        check("basic_pulse", bus14.oVALID, 1'b0);
        repeat (5) tick();
        check("basic_hold", bus14.oBCD, 16'h1234);

        // Boundaries
        for (int i = 0; i < 6; i++) begin
            run(14, bVals[i], bExp[i], bOvf[i], $sformatf("bnd%0d", bVals[i]));
        end
        repeat (4) tick();
        check("ovf_hold", bus14.oOVF, 1'b1);

        // Back-to-back with iSTART held; iBIN changes mid-conversion
        bus14.iBIN = 14'd1;
        bus14.iSTART = 1'b1;
        tick();
        bus14.iBIN = 14'd2;
        waitValid(14, cnt, busyCnt);
        check("b2b1_lat", cnt, 15);
        check("b2b1_bcd", bus14.oBCD, 16'h0001);
        tick();
        check("b2b2_accept", bus14.oBUSY, 1'b1);
        bus14.iBIN = 14'd3;
        waitValid(14, cnt, busyCnt);
        check("b2b2_lat", cnt, 15);
        check("b2b2_bcd", bus14.oBCD, 16'h0002);
        tick();
        bus14.iSTART = 1'b0;
        bus14.iBIN = 14'd77;
        waitValid(14, cnt, busyCnt);
        check("b2b3_lat", cnt, 15);
        check("b2b3_bcd", bus14.oBCD, 16'h0003);

        // iSTART pulse mid-conversion is ignored and not queued
        repeat (2) tick();
        startConv(14, 500);
        repeat (4) tick();
        bus14.iBIN = 14'd7;
        bus14.iSTART = 1'b1;
        tick();
        bus14.iSTART = 1'b0;
        waitValid(14, cnt, busyCnt);
        check("ign_lat", cnt, 10);
        check("ign_bcd", bus14.oBCD, 16'h0500);
        seen = 0;
        busySeen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen += int'(bus14.oVALID);
            busySeen += int'(bus14.oBUSY);
        end
        check("ign_novalid", seen, 0);
        check("ign_nobusy", busySeen, 0);

        // Reset mid-conversion
        startConv(14, 4321);
        repeat (6) tick();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        check("mrst_bcd", bus14.oBCD, 16'h0000);
        check("mrst_busy", bus14.oBUSY, 1'b0);
        check("mrst_valid", bus14.oVALID, 1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen += int'(bus14.oVALID);
        end
        check("mrst_novalid", seen, 0);
        run(14, 4321, 16'h4321, 1'b0, "mrst_again");

        // BIN_W = 4, exhaustive
        for (int i = 0; i < 16; i++) begin
            run(4, i, refBcd(i), 1'b0, $sformatf("w4_%0d", i));
        end

        // BIN_W = 16, corner and random samples
        run(16, 65535, EXP_65535, 1'b1, "w16_max");
        run(16, 9999, 16'h9999, 1'b0, "w16_9999");
        run(16, 10000, EXP_10000, 1'b1, "w16_10000");
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(65535, 0));
            run(16, v, refBcd(v), v > 9999, $sformatf("w16_rnd%0d", v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
